i2c_master_mb: RTL and testbench

Parametrised multi-byte I2C master. Generates SCL from the system clock through a programmable divider and drives the bus open-drain. Runs write or read transactions of 1..2^LEN_W-1 bytes with per-byte ACK checking and NACK abort. Byte streams use valid/ready handshakes. Sits between controller logic and the board-level I2C pads.

---
 rtl/i2c_master_mb.sv | 181 ++++++++++++++++++
 tb/tb_i2c_master_mb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_mb.sv
// Multi-byte I2C master: divided SCL, open-drain style pull controls, valid/ready byte streams.
// Each bit is four quarters of DIV clocks; SCL is pulled low in Q0-Q1 and SDA changes only at Q0 entry.
module i2c_master_mb #(
   parameter int DIV   = 4,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             rw,
   input  logic [6:0]       addr,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic             nack,
   output logic             scl_low,
   output logic             sda_low,
   input  logic             sda_in
);

   // state     | meaning
   // S_IDLE    | bus released, waiting for start
   // S_START   | START condition: SDA falls while SCL is high
   // S_ADDR    | 7 address bits then rw, MSB first
   // S_ACK_A   | slave acknowledge of the address
   // S_WR_WAIT | next write byte not yet valid; SCL held low, timer frozen
   // S_WR_BIT  | 8 write data bits, MSB first
   // S_ACK_W   | slave acknowledge of a write byte
   // S_RD_BIT  | 8 read data bits sampled from the slave
   // S_MACK    | master ACK (more bytes) or NACK (last byte)
   // S_STOP    | STOP condition: SDA rises while SCL is high
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK_A, S_WR_WAIT,
      S_WR_BIT, S_ACK_W, S_RD_BIT, S_MACK, S_STOP
   } state_t;

   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(DIV - 1);

   state_t           state, state_d;
   logic [TW-1:0]    tmr;
   logic [1:0]       q;
   logic [2:0]       bit_cnt;
   logic [LEN_W-1:0] byte_cnt;
   logic [7:0]       shift;
   logic [6:0]       rx;
   logic             rw_r;
   logic             tc, bit_end, smp, accept, last_byte;

   assign tc        = (tmr == '0);
   assign bit_end   = tc && (q == 2'd3);
   assign smp       = tc && (q == 2'd2);
   assign accept    = start && (state == S_IDLE);
   assign last_byte = (byte_cnt == LEN_W'(1));
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d  = state;
      wr_ready = 1'b0;
      scl_low  = ~q[1];
      sda_low  = 1'b0;
      case (state)
         S_IDLE: begin
            scl_low = 1'b0;
            if (start) state_d = S_START;
         end
         S_START: begin
            scl_low = 1'b0;
            sda_low = q[1];
            if (bit_end) state_d = S_ADDR;
         end
         S_ADDR: begin
            sda_low = ~shift[7];
            if (bit_end && bit_cnt == 3'd0) state_d = S_ACK_A;
         end
         S_ACK_A, S_ACK_W: begin
            if (bit_end) begin
               if (nack || (state == S_ACK_W && last_byte)) state_d = S_STOP;
               else if (state == S_ACK_A && rw_r)          state_d = S_RD_BIT;
               else if (wr_valid) begin
                  state_d  = S_WR_BIT;
                  wr_ready = 1'b1;
               end else                                    state_d = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            scl_low = 1'b1;
            if (wr_valid) begin
               state_d  = S_WR_BIT;
               wr_ready = 1'b1;
            end
         end
         S_WR_BIT: begin
            sda_low = ~shift[7];
            if (bit_end && bit_cnt == 3'd0) state_d = S_ACK_W;
         end
         S_RD_BIT: begin
            if (bit_end && bit_cnt == 3'd0) state_d = S_MACK;
         end
         S_MACK: begin
            sda_low = ~last_byte;
            if (bit_end) state_d = last_byte ? S_STOP : S_RD_BIT;
         end
         S_STOP: begin
            sda_low = (q != 2'd3);
            if (bit_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmr      <= '0;
         q        <= 2'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= '0;
         shift    <= 8'h00;
         rx       <= 7'h00;
         rw_r     <= 1'b0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         nack     <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;

         // Quarter timer is parked at full count while idle or stalled for write data.
         if (state == S_IDLE || state == S_WR_WAIT) begin
            tmr <= TMR_LOAD;
            q   <= 2'd0;
         end else if (tc) begin
            tmr <= TMR_LOAD;
            q   <= q + 2'd1;
         end else begin
            tmr <= tmr - TW'(1);
         end

         if (accept) begin
            rw_r     <= rw;
            shift    <= {addr, rw};
            byte_cnt <= (len == '0) ? LEN_W'(1) : len;
            nack     <= 1'b0;
            bit_cnt  <= 3'd7;
         end

         if (wr_ready) shift <= wr_data;

         if (bit_end) begin
            bit_cnt <= (state_d != state) ? 3'd7 : bit_cnt - 3'd1;
            if (state == S_ADDR || state == S_WR_BIT) shift <= {shift[6:0], 1'b0};
            if ((state == S_ACK_W || state == S_MACK) && !last_byte)
               byte_cnt <= byte_cnt - LEN_W'(1);
            if (state == S_STOP) done <= 1'b1;
         end

         if (smp) begin
            if ((state == S_ACK_A || state == S_ACK_W) && sda_in) nack <= 1'b1;
            if (state == S_RD_BIT) begin
               rx <= {rx[5:0], sda_in};
               if (bit_cnt == 3'd0) begin
                  rd_data  <= {rx, sda_in};
                  rd_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_mb.sv
// Directed bench for i2c_master_mb (DIV=2): scripted slave on SDA, bus monitor, per-scenario checks.
module tb_i2c_master_mb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [3:0] len = 4'd0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid, busy, done, nack, scl_low, sda_low;
   logic       sda_bus;
   logic       slave_low = 1'b0;

   int total = 0;
   int bad = 0;

   logic        mon_clr = 1'b1;
   logic [63:0] scr = 64'd0;
   logic [7:0]  wd [4];
   logic        bus_bit [64];
   logic        mst_bit [64];
   int          rise_t [64];
   logic [7:0]  rdv [8];
   int rise_n = 0, bits_n = 0, wrr_n = 0, done_n = 0, rdv_n = 0, start_n = 0, stop_n = 0, ncyc = 0;
   logic scl_p = 1'b0, sda_p = 1'b1;

   assign sda_bus = !(sda_low || slave_low);

   i2c_master_mb #(.DIV(2), .LEN_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .len(len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
      .scl_low(scl_low), .sda_low(sda_low), .sda_in(sda_bus)
   );

   always #5 clk = ~clk;

   // Bus monitor and scripted slave: slave drive for bit n is taken from scr[n] when SCL falls into bit n.
   always @(negedge clk) begin
      if (mon_clr) begin
         rise_n = 0; bits_n = 0; wrr_n = 0; done_n = 0; rdv_n = 0; start_n = 0; stop_n = 0;
         slave_low = 1'b0;
      end else begin
         if (!scl_p && !scl_low && sda_p && !sda_bus) start_n++;
         if (!scl_p && !scl_low && !sda_p && sda_bus) stop_n++;
         if (scl_low && !scl_p) begin
            slave_low = (rise_n < 64) ? scr[rise_n] : 1'b0;
            rise_n++;
         end
         if (!scl_low && scl_p && bits_n < 64) begin
            bus_bit[bits_n] = sda_bus;
            mst_bit[bits_n] = sda_low;
            rise_t[bits_n]  = ncyc;
            bits_n++;
         end
         if (wr_ready) wrr_n++;
         if (done) done_n++;
         if (rd_valid && rdv_n < 8) begin
            rdv[rdv_n] = rd_data;
            rdv_n++;
         end
      end
      scl_p = scl_low;
      sda_p = sda_bus;
      ncyc++;
   end

   task automatic run_txn(input logic rw_i, input logic [6:0] addr_i, input logic [3:0] len_i,
                          input int nw, input int stall_rise, input int extra_start,
                          output logic to, output logic busy_done, output int stall_low);
      int idx, stall_left;
      logic pend, stalling;
      mon_clr = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mon_clr = 1'b0;
      idx = 0; pend = 1'b0; stalling = 1'b0; stall_left = 20; stall_low = 0;
      to = 1'b1; busy_done = 1'b1;
      rw = rw_i; addr = addr_i; len = len_i;
      wr_data = wd[0]; wr_valid = (nw > 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == extra_start);
         if (cyc == extra_start) begin
            rw = 1'b1;
            addr = 7'h11;
         end
         if (pend) begin
            idx++;
            pend = 1'b0;
            wr_data = wd[idx % 4];
            wr_valid = (idx < nw);
            if (stall_rise > 0 && idx == 1) begin
               stalling = 1'b1;
               wr_valid = 1'b0;
            end
         end
         if (stalling && rise_n >= stall_rise) begin
            if (scl_low) stall_low++;
            stall_left--;
            if (stall_left == 0) begin
               stalling = 1'b0;
               wr_valid = (idx < nw);
            end
         end
         #1;
         if (wr_ready) pend = 1'b1;
         if (done) begin
            to = 1'b0;
            busy_done = busy;
            break;
         end
      end
      start = 1'b0;
      wr_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      total++; if (scl_low !== 1'b0) begin bad++; $display("FAIL reset_scl got=%b want=0", scl_low); end
      total++; if (sda_low !== 1'b0) begin bad++; $display("FAIL reset_sda got=%b want=0", sda_low); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (nack !== 1'b0) begin bad++; $display("FAIL reset_nack got=%b want=0", nack); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
   endtask

   task automatic test_write;
      logic to, bd;
      int sl;
      logic [26:0] obs, exp_v;
      wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'h00; wd[3] = 8'h00;
      scr = 64'd0; scr[8] = 1'b1; scr[17] = 1'b1; scr[26] = 1'b1;
      run_txn(1'b0, 7'h50, 4'd2, 2, 0, -1, to, bd, sl);
      for (int i = 0; i < 27; i++) obs[26-i] = bus_bit[i];
      exp_v = {8'hA0, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0};
      total++; if (to !== 1'b0) begin bad++; $display("FAIL write_timeout got=%b want=0", to); end
      total++; if (bits_n != 28) begin bad++; $display("FAIL write_bits got=%0d want=28", bits_n); end
      total++; if (obs !== exp_v) begin bad++; $display("FAIL write_sda got=%h want=%h", obs, exp_v); end
      total++; if (bus_bit[27] !== 1'b0) begin bad++; $display("FAIL write_stop_low got=%b want=0", bus_bit[27]); end
      total++; if (rise_t[1] - rise_t[0] != 8) begin bad++; $display("FAIL write_period got=%0d want=8", rise_t[1] - rise_t[0]); end
      total++; if (rise_t[9] - rise_t[8] != 8) begin bad++; $display("FAIL write_ack_period got=%0d want=8", rise_t[9] - rise_t[8]); end
      total++; if (wrr_n != 2) begin bad++; $display("FAIL write_wr_ready got=%0d want=2", wrr_n); end
      total++; if (done_n != 1) begin bad++; $display("FAIL write_done got=%0d want=1", done_n); end
      total++; if (nack !== 1'b0) begin bad++; $display("FAIL write_nack got=%b want=0", nack); end
      total++; if (start_n != 1 || stop_n != 1) begin bad++; $display("FAIL write_start_stop got=%0d/%0d want=1/1", start_n, stop_n); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL write_busy_at_done got=%b want=0", bd); end
   endtask

   task automatic test_read;
      logic to, bd;
      int sl;
      logic [7:0] rb [3];
      logic [7:0] a_obs;
      rb[0] = 8'h12; rb[1] = 8'h34; rb[2] = 8'h56;
      scr = 64'd0; scr[8] = 1'b1;
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 8; i++) scr[9 + 9*b + i] = ~rb[b][7-i];
      run_txn(1'b1, 7'h68, 4'd3, 0, 0, -1, to, bd, sl);
      for (int i = 0; i < 8; i++) a_obs[7-i] = bus_bit[i];
      total++; if (to !== 1'b0) begin bad++; $display("FAIL read_timeout got=%b want=0", to); end
      total++; if (a_obs !== 8'hD1) begin bad++; $display("FAIL read_addr got=%h want=d1", a_obs); end
      total++; if (rdv_n != 3) begin bad++; $display("FAIL read_count got=%0d want=3", rdv_n); end
      total++; if (rdv[0] !== 8'h12) begin bad++; $display("FAIL read_b0 got=%h want=12", rdv[0]); end
      total++; if (rdv[1] !== 8'h34) begin bad++; $display("FAIL read_b1 got=%h want=34", rdv[1]); end
      total++; if (rdv[2] !== 8'h56) begin bad++; $display("FAIL read_b2 got=%h want=56", rdv[2]); end
      total++; if (mst_bit[17] !== 1'b1 || mst_bit[26] !== 1'b1) begin bad++; $display("FAIL read_mack got=%b%b want=11", mst_bit[17], mst_bit[26]); end
      total++; if (mst_bit[35] !== 1'b0) begin bad++; $display("FAIL read_last_nack got=%b want=0", mst_bit[35]); end
      total++; if (bits_n != 37) begin bad++; $display("FAIL read_bits got=%0d want=37", bits_n); end
      total++; if (done_n != 1 || stop_n != 1) begin bad++; $display("FAIL read_done_stop got=%0d/%0d want=1/1", done_n, stop_n); end
      total++; if (nack !== 1'b0) begin bad++; $display("FAIL read_nack got=%b want=0", nack); end
   endtask

   task automatic test_nack;
      logic to, bd;
      int sl;
      logic [7:0] a_obs;
      wd[0] = 8'hFF;
      scr = 64'd0;
      run_txn(1'b0, 7'h22, 4'd1, 1, 0, -1, to, bd, sl);
      for (int i = 0; i < 8; i++) a_obs[7-i] = bus_bit[i];
      total++; if (to !== 1'b0) begin bad++; $display("FAIL nack_timeout got=%b want=0", to); end
      total++; if (nack !== 1'b1) begin bad++; $display("FAIL nack_flag got=%b want=1", nack); end
      total++; if (wrr_n != 0) begin bad++; $display("FAIL nack_wr_ready got=%0d want=0", wrr_n); end
      total++; if (a_obs !== 8'h44) begin bad++; $display("FAIL nack_addr got=%h want=44", a_obs); end
      total++; if (bits_n != 10) begin bad++; $display("FAIL nack_bits got=%0d want=10", bits_n); end
      total++; if (stop_n != 1 || done_n != 1) begin bad++; $display("FAIL nack_stop_done got=%0d/%0d want=1/1", stop_n, done_n); end
   endtask

   task automatic test_stall;
      logic to, bd;
      int sl;
      logic [26:0] obs, exp_v;
      wd[0] = 8'hC3; wd[1] = 8'h96; wd[2] = 8'h00; wd[3] = 8'h00;
      scr = 64'd0; scr[8] = 1'b1; scr[17] = 1'b1; scr[26] = 1'b1;
      run_txn(1'b0, 7'h3A, 4'd2, 2, 19, -1, to, bd, sl);
      for (int i = 0; i < 27; i++) obs[26-i] = bus_bit[i];
      exp_v = {8'h74, 1'b0, 8'hC3, 1'b0, 8'h96, 1'b0};
      total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout got=%b want=0", to); end
      total++; if (sl != 20) begin bad++; $display("FAIL stall_scl_low got=%0d want=20", sl); end
      total++; if (obs !== exp_v) begin bad++; $display("FAIL stall_sda got=%h want=%h", obs, exp_v); end
      total++; if (rise_t[18] - rise_t[17] < 28) begin bad++; $display("FAIL stall_gap got=%0d want>=28", rise_t[18] - rise_t[17]); end
      total++; if (rise_t[19] - rise_t[18] != 8) begin bad++; $display("FAIL stall_period got=%0d want=8", rise_t[19] - rise_t[18]); end
      total++; if (wrr_n != 2 || done_n != 1) begin bad++; $display("FAIL stall_counts got=%0d/%0d want=2/1", wrr_n, done_n); end
   endtask

   task automatic test_reset_mid;
      logic to, bd, hit;
      int sl;
      logic [17:0] obs, exp_v;
      mon_clr = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mon_clr = 1'b0;
      scr = 64'd0;
      rw = 1'b0; addr = 7'h50; len = 4'd1; wd[0] = 8'h5A; wr_data = 8'h5A; wr_valid = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (rise_n >= 4) begin
            hit = 1'b1;
            break;
         end
      end
      total++; if (hit !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rmid_reach_bit3 got=%b/%b want=1/1", hit, busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (scl_low !== 1'b0 || sda_low !== 1'b0) begin bad++; $display("FAIL rmid_bus got=%b%b want=00", scl_low, sda_low); end
      total++; if (busy !== 1'b0 || nack !== 1'b0) begin bad++; $display("FAIL rmid_flags got=%b%b want=00", busy, nack); end
      reset = 1'b0;
      wr_valid = 1'b0;
      @(posedge clk); #1;
      scr = 64'd0; scr[8] = 1'b1; scr[17] = 1'b1;
      run_txn(1'b0, 7'h50, 4'd1, 1, 0, -1, to, bd, sl);
      for (int i = 0; i < 18; i++) obs[17-i] = bus_bit[i];
      exp_v = {8'hA0, 1'b0, 8'h5A, 1'b0};
      total++; if (to !== 1'b0 || done_n != 1) begin bad++; $display("FAIL rmid_redo_done got=%b/%0d want=0/1", to, done_n); end
      total++; if (obs !== exp_v) begin bad++; $display("FAIL rmid_redo_sda got=%h want=%h", obs, exp_v); end
      total++; if (nack !== 1'b0) begin bad++; $display("FAIL rmid_redo_nack got=%b want=0", nack); end
   endtask

   task automatic test_busy_start;
      logic to, bd;
      int sl;
      logic [17:0] obs, exp_v;
      wd[0] = 8'h77; wd[1] = 8'h88; wd[2] = 8'h00; wd[3] = 8'h00;
      scr = 64'd0; scr[8] = 1'b1; scr[17] = 1'b1;
      run_txn(1'b0, 7'h2D, 4'd0, 2, 0, 30, to, bd, sl);
      for (int i = 0; i < 18; i++) obs[17-i] = bus_bit[i];
      exp_v = {8'h5A, 1'b0, 8'h77, 1'b0};
      total++; if (to !== 1'b0) begin bad++; $display("FAIL len0_timeout got=%b want=0", to); end
      total++; if (wrr_n != 1) begin bad++; $display("FAIL len0_wr_ready got=%0d want=1", wrr_n); end
      total++; if (bits_n != 19) begin bad++; $display("FAIL len0_bits got=%0d want=19", bits_n); end
      total++; if (obs !== exp_v) begin bad++; $display("FAIL len0_sda got=%h want=%h", obs, exp_v); end
      total++; if (start_n != 1 || done_n != 1) begin bad++; $display("FAIL len0_start_done got=%0d/%0d want=1/1", start_n, done_n); end
      repeat (10) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_idle_after got=%b want=0", busy); end
   endtask

   initial begin
      wd[0] = 8'h00; wd[1] = 8'h00; wd[2] = 8'h00; wd[3] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_reset_mid();
      test_stall();
      test_busy_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
